mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Single-ported memory front end for the multicycle MIPS core. It turns the control FSM's per-state memory strobes into a registered valid/ready transaction on a variable-latency memory bus. It holds the instruction register that supplies `opcode`/`funct` to the control unit and the memory data register used on load write-back. While an access is outstanding it asserts `stall`, and the control FSM holds its current state and strobes.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum BUSY cycles without `bus_ready` before a fault is declared; legal range 1..65535.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pc` in 32: fetch address; used when `i_or_d`=0.
- `alu_out` in 32: data address; used when `i_or_d`=1.
- `write_data` in 32: store data (B register).
- `i_or_d` in 1: address select.
- `ir_write` in 1: instruction fetch strobe.
- `mem_read` in 1: load strobe.
- `mem_write` in 1: store strobe.
- `stall` out 1: control FSM must not advance while high.
- `instr` out 32: instruction register.
- `opcode` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `mem_data` out 32: memory data register.
- `fault` out 1: sticky error flag.
- `fault_addr` out 32: address of the faulting access.
- `bus_req` out 1: request valid.
- `bus_we` out 1: write request.
- `bus_addr` out 32: word-aligned request address.
- `bus_wdata` out 32: request write data.
- `bus_ready` in 1: memory completes the request this cycle.
- `bus_rdata` in 32: read data, valid when `bus_ready`=1.

## Operation
- States: IDLE, BUSY, COMPLETE, FAULT.
- **IDLE**
  - Strobe = `ir_write | mem_read | mem_write`.
  - Address = `i_or_d ? alu_out : pc`.
  - If strobe and address[1:0]==0: capture address, `write_data` and kind; go to BUSY.
  - If strobe and address misaligned: capture `fault_addr`; go to FAULT. No bus request is issued.
  - Simultaneous strobes: priority `mem_write` > `ir_write` > `mem_read`. Only the winner is performed.
- **BUSY**
  - `bus_req`=1; `bus_addr`, `bus_we`, `bus_wdata` are driven from the captured registers and stay stable until accepted.
  - On `bus_ready`=1:
    - fetch: `instr` <= `bus_rdata`;
    - load: `mem_data` <= `bus_rdata`;
    - store: no register update.
    - Then go to COMPLETE.
  - A timeout counter clears on entry to BUSY and increments each BUSY cycle without `bus_ready`. When it reaches `TIMEOUT` with `bus_ready` still 0: capture `fault_addr`, go to FAULT.
- **COMPLETE**
  - One cycle with `stall`=0 so the control FSM advances.
  - Strobes are ignored in this cycle, since they are the same held strobes.
  - Always returns to IDLE.
- **FAULT**
  - Sticky: `fault`=1, `stall`=1, `bus_req`=0.
  - Only `reset` exits.
- **`stall`** (combinational) = `(IDLE & strobe) | BUSY | FAULT`.
- **Bus outputs**: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` are register-driven; `bus_we`, `bus_addr`, `bus_wdata` hold 0 outside BUSY.
- **`bus_ready` outside BUSY**: ignored; never updates `instr` or `mem_data`.

## Timing
- **Reset values**: state IDLE; `instr`=0 (so `opcode`=0, `funct`=0, sll nop); `mem_data`=0; `fault`=0; `fault_addr`=0; `bus_req`=0; `bus_we`=0; `bus_addr`=0; `bus_wdata`=0; `stall` reflects strobes only.
- **Minimum access** is 3 cycles:
  - cycle 0: IDLE, strobe, `stall`=1;
  - cycle 1: BUSY, `bus_req`=1, `bus_ready`=1;
  - cycle 2: COMPLETE, `stall`=0, new `instr`/`mem_data` visible.
- **Access latency** = 2 + number of BUSY cycles.
- **Timeout**: with `bus_ready` held 0, FAULT is entered after exactly `TIMEOUT` BUSY cycles.
- **`bus_ready` on the timeout cycle**: completes normally; it takes precedence over the timeout.
- **Reset mid-transaction**: asynchronous; `bus_req` drops immediately, registers return to reset values, and no partial update occurs.
- **Back-to-back accesses**: strobe held into IDLE after COMPLETE starts a new access immediately. The minimum gap between `bus_req` pulses is 2 cycles.

## Test plan
- **Fetch**: `pc`=0x0000_0040, `ir_write`=1, `i_or_d`=0; memory answers 0x0123_4020 one cycle after `bus_req` -> `bus_addr`=0x40, `bus_we`=0, `stall` high 2 cycles then low in COMPLETE; `instr`=0x0123_4020, `opcode`=0, `funct`=0x20.
- **Load with wait states**: `alu_out`=0x100, `mem_read`=1, `i_or_d`=1, `bus_ready` after 4 BUSY cycles with `bus_rdata`=0xDEAD_BEEF -> `bus_req` high 4 cycles; `mem_data`=0xDEAD_BEEF; `instr` unchanged; total `stall`=5 cycles.
- **Store**: `alu_out`=0x200, `write_data`=0xCAFE_F00D, `mem_write`=1 -> `bus_we`=1, `bus_wdata`=0xCAFE_F00D while BUSY; `mem_data`/`instr` unchanged.
- **Misaligned load**: `alu_out`=0x102 -> no `bus_req`; `fault`=1 next cycle; `fault_addr`=0x102; `stall` stays 1 until reset.
- **Timeout**: `TIMEOUT`=3, `bus_ready` never asserted -> exactly 3 `bus_req` cycles, then FAULT with `fault_addr` = request address. Repeat with `bus_ready`=1 on the 3rd BUSY cycle -> normal completion, `fault`=0.
- **Async reset**: assert `reset` mid-BUSY, between clock edges -> `bus_req`=0 and `instr`=0 immediately. After release, `bus_ready` pulses are ignored and a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory front end for the multicycle core. It turns the per-state memory
// strobes from the control FSM into one registered valid/ready bus
// transaction. It holds the instruction register (IR) and the memory data
// register (MDR), and asserts stall while an access is outstanding.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a strobe; an aligned address launches a request
// BUSY     | bus_req high, waiting for bus_ready or the timeout
// COMPLETE | one stall-free cycle so the control FSM advances
// FAULT    | sticky error (misaligned or timed out); only reset leaves it
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] write_data,
   input  logic        i_or_d,
   input  logic        ir_write,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic        stall,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] mem_data,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY     = 2'd1,
      ST_COMPLETE = 2'd2,
      ST_FAULT    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_FETCH = 2'd0,
      K_LOAD  = 2'd1,
      K_STORE = 2'd2
   } kind_t;

   // The wait timer counts down from TIMEOUT-1; expiry is the BUSY cycle
   // that finds it at zero with bus_ready still low.
   localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

   state_t      state_q;
   kind_t       kind_q;
   kind_t       kind_d;
   logic [15:0] tmr_q;
   logic [31:0] instr_q;
   logic [31:0] mem_data_q;
   logic        fault_q;
   logic [31:0] fault_addr_q;
   logic        bus_req_q;
   logic        bus_we_q;
   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;

   logic        strobe;
   logic [31:0] addr_sel;

   assign strobe   = ir_write | mem_read | mem_write;
   assign addr_sel = i_or_d ? alu_out : pc;

   // Pick the single winning access when several strobes are high.
   always_comb begin
      kind_d = K_LOAD;
      if (mem_write)     kind_d = K_STORE;
      else if (ir_write) kind_d = K_FETCH;
   end

   // Access sequencer with registered bus outputs, IR and MDR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         kind_q       <= K_FETCH;
         tmr_q        <= '0;
         instr_q      <= '0;
         mem_data_q   <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (strobe) begin
                  if (addr_sel[1:0] == 2'b00) begin
                     state_q     <= ST_BUSY;
                     kind_q      <= kind_d;
                     tmr_q       <= TMR_LOAD;
                     bus_req_q   <= 1'b1;
                     bus_we_q    <= (kind_d == K_STORE);
                     bus_addr_q  <= addr_sel;
                     bus_wdata_q <= write_data;
                  end else begin
                     state_q      <= ST_FAULT;
                     fault_q      <= 1'b1;
                     fault_addr_q <= addr_sel;
                  end
               end
            end
            ST_BUSY: begin
               if (bus_ready) begin
                  case (kind_q)
                     K_FETCH: instr_q    <= bus_rdata;
                     K_LOAD:  mem_data_q <= bus_rdata;
                     default: ;
                  endcase
                  state_q     <= ST_COMPLETE;
                  bus_req_q   <= 1'b0;
                  bus_we_q    <= 1'b0;
                  bus_addr_q  <= '0;
                  bus_wdata_q <= '0;
               end else if (tmr_q == 16'd0) begin
                  state_q      <= ST_FAULT;
                  fault_q      <= 1'b1;
                  fault_addr_q <= bus_addr_q;
                  bus_req_q    <= 1'b0;
                  bus_we_q     <= 1'b0;
                  bus_addr_q   <= '0;
                  bus_wdata_q  <= '0;
               end else begin
                  tmr_q <= tmr_q - 16'd1;
               end
            end
            // The strobes seen here are the ones just serviced; drop them.
            ST_COMPLETE: state_q <= ST_IDLE;
            ST_FAULT:    state_q <= ST_FAULT;
            default:     state_q <= ST_IDLE;
         endcase
      end
   end

   // Stall as soon as a strobe appears so the control FSM never runs ahead.
   always_comb begin
      stall = 1'b0;
      case (state_q)
         ST_IDLE:  stall = strobe;
         ST_BUSY:  stall = 1'b1;
         ST_FAULT: stall = 1'b1;
         default:  stall = 1'b0;
      endcase
   end

   assign instr      = instr_q;
   assign opcode     = instr_q[31:26];
   assign funct      = instr_q[5:0];
   assign mem_data   = mem_data_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// random accesses, checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;

   localparam int TMO = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc, alu_out, write_data;
   logic        i_or_d, ir_write, mem_read, mem_write;
   logic        stall;
   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [31:0] mem_data;
   logic        fault;
   logic [31:0] fault_addr;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_instr;
   logic [31:0] exp_mdata;
   bit          faulted;

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .pc(pc), .alu_out(alu_out),
      .write_data(write_data), .i_or_d(i_or_d), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write), .stall(stall),
      .instr(instr), .opcode(opcode), .funct(funct), .mem_data(mem_data),
      .fault(fault), .fault_addr(fault_addr), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag);
      check_eq({tag, ".instr"}, instr, exp_instr);
      check_eq({tag, ".opcode"}, {26'd0, opcode}, {26'd0, exp_instr[31:26]});
      check_eq({tag, ".funct"}, {26'd0, funct}, {26'd0, exp_instr[5:0]});
      check_eq({tag, ".mem_data"}, mem_data, exp_mdata);
   endtask

   // Reset between clock edges, then show bus_ready is ignored while idle.
   task automatic do_reset();
      @(posedge clk);
      ir_write = 0; mem_read = 0; mem_write = 0; bus_ready = 0;
      #2 reset = 1;
      #1;
      exp_instr = '0; exp_mdata = '0; faulted = 0;
      check_eq("rst.bus_req", bus_req, 0);
      check_eq("rst.fault", fault, 0);
      check_eq("rst.fault_addr", fault_addr, 0);
      check_eq("rst.stall", stall, 0);
      check_regs("rst");
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         bus_ready = 1; bus_rdata = $urandom;
         #2;
         check_eq("idle_rdy.stall", stall, 0);
         check_eq("idle_rdy.bus_req", bus_req, 0);
         check_regs("idle_rdy");
      end
      bus_ready = 0;
   endtask

   // One access. lat = BUSY cycle carrying bus_ready (0 = never);
   // abort_at = BUSY cycle in which reset is pulsed (0 = none).
   task automatic access(input logic ir, input logic rd, input logic wr,
                         input logic iod, input logic [31:0] pc_v,
                         input logic [31:0] alu_v, input logic [31:0] wd_v,
                         input logic [31:0] rdata_v, input int lat,
                         input int abort_at);
      logic [31:0] addr;
      bit          is_store, is_fetch;
      addr     = iod ? alu_v : pc_v;
      is_store = wr;
      is_fetch = !wr && ir;
      step();
      ir_write = ir; mem_read = rd; mem_write = wr; i_or_d = iod;
      pc = pc_v; alu_out = alu_v; write_data = wd_v;
      bus_ready = 0; bus_rdata = $urandom;
      #2;
      check_eq("idle.stall", stall, 1);
      check_eq("idle.bus_req", bus_req, 0);
      if (addr[1:0] != 2'b00) begin
         step();
         bus_ready = 1; bus_rdata = $urandom;
         #2;
         check_eq("mis.fault", fault, 1);
         check_eq("mis.fault_addr", fault_addr, addr);
         check_eq("mis.bus_req", bus_req, 0);
         check_eq("mis.stall", stall, 1);
         check_regs("mis");
         faulted = 1;
         return;
      end
      for (int b = 1; b <= TMO; b++) begin
         step();
         bus_ready = (b == lat);
         bus_rdata = (b == lat) ? rdata_v : $urandom;
         #2;
         check_eq("busy.bus_req", bus_req, 1);
         check_eq("busy.bus_we", bus_we, is_store);
         check_eq("busy.bus_addr", bus_addr, addr);
         check_eq("busy.stall", stall, 1);
         check_eq("busy.fault", fault, 0);
         if (is_store) check_eq("busy.bus_wdata", bus_wdata, wd_v);
         if (b == abort_at) begin
            reset = 1;
            #1;
            exp_instr = '0; exp_mdata = '0;
            check_eq("abort.bus_req", bus_req, 0);
            check_eq("abort.bus_addr", bus_addr, 0);
            check_eq("abort.fault", fault, 0);
            check_regs("abort");
            ir_write = 0; mem_read = 0; mem_write = 0; bus_ready = 0;
            @(negedge clk);
            reset = 0;
            return;
         end
         if (b == lat) begin
            if (is_fetch) exp_instr = rdata_v;
            else if (!is_store) exp_mdata = rdata_v;
            step();
            bus_ready = 1; bus_rdata = $urandom;
            #2;
            check_eq("cmp.stall", stall, 0);
            check_eq("cmp.bus_req", bus_req, 0);
            check_eq("cmp.bus_we", bus_we, 0);
            check_eq("cmp.bus_addr", bus_addr, 0);
            check_eq("cmp.bus_wdata", bus_wdata, 0);
            check_eq("cmp.fault", fault, 0);
            check_regs("cmp");
            bus_ready = 0;
            return;
         end
      end
      for (int i = 0; i < 2; i++) begin
         step();
         bus_ready = (i == 1); bus_rdata = $urandom;
         #2;
         check_eq("tmo.fault", fault, 1);
         check_eq("tmo.fault_addr", fault_addr, addr);
         check_eq("tmo.bus_req", bus_req, 0);
         check_eq("tmo.bus_addr", bus_addr, 0);
         check_eq("tmo.stall", stall, 1);
         check_regs("tmo");
      end
      faulted = 1;
   endtask

   initial begin
      reset = 1;
      pc = '0; alu_out = '0; write_data = '0; i_or_d = 0;
      ir_write = 0; mem_read = 0; mem_write = 0;
      bus_ready = 0; bus_rdata = '0;
      exp_instr = '0; exp_mdata = '0; faulted = 0;
      #2;
      check_eq("por.bus_req", bus_req, 0);
      check_eq("por.stall", stall, 0);
      check_eq("por.fault", fault, 0);
      check_regs("por");
      ir_write = 1;
      #1 check_eq("por.stall_strobe", stall, 1);
      ir_write = 0;
      @(negedge clk);
      reset = 0;

      // fetch, load with 4 wait states, store
      access(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0123_4020, 1, 0);
      access(0, 1, 0, 1, 32'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4, 0);
      access(0, 0, 1, 1, 32'h0, 32'h200, 32'hCAFE_F00D, 32'h5555_AAAA, 2, 0);
      // all strobes together: store wins
      access(1, 1, 1, 1, 32'h80, 32'h300, 32'h1234_5678, 32'h7777_7777, 1, 0);
      // misaligned load
      access(0, 1, 0, 1, 32'h0, 32'h102, 32'h0, 32'h0, 1, 0);
      do_reset();
      // timeout, then ready on the final allowed cycle
      access(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h0, 0, 0);
      do_reset();
      access(0, 1, 0, 1, 32'h0, 32'h104, 32'h0, 32'hA5A5_0001, TMO, 0);
      // reset mid-BUSY, then a clean fetch
      access(1, 0, 0, 0, 32'h48, 32'h0, 32'h0, 32'h1111_1111, 4, 2);
      do_reset();
      access(1, 0, 0, 0, 32'h4C, 32'h0, 32'h0, 32'h2000_002A, 1, 0);

      for (int n = 0; n < 150; n++) begin
         logic [2:0]  s;
         logic [31:0] a_pc, a_alu;
         int          lat;
         s = 3'($urandom_range(1, 7));
         a_pc  = $urandom & 32'hFFFF_FFFC;
         a_alu = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) a_alu[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 19) == 0) a_pc[1:0] = 2'($urandom_range(1, 3));
         lat = $urandom_range(0, 8) == 0 ? 0 : $urandom_range(1, TMO);
         access(s[0], s[1], s[2], 1'($urandom), a_pc, a_alu, $urandom, $urandom, lat, 0);
         if (faulted) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
